// File: rtl/rom_file_pkg.sv
// Shared helpers for the ROM-based multiplier: operand/depth sizing and the
// elaboration-time table entry function.
package rom_file_pkg;

    localparam int MAX_N = 32;

    function automatic int op_width(input int n);
        return n / 2;
    endfunction

    function automatic int rom_depth(input int n);
        return 1 << n;
    endfunction

    // Upper half of the address times lower half; always fits in n bits.
    function automatic logic [MAX_N-1:0] mult_entry(input int unsigned addr, input int n);
        int unsigned hi;
        int unsigned lo;
        int unsigned mask;
        mask = (32'd1 << op_width(n)) - 32'd1;
        hi   = addr >> op_width(n);
        lo   = addr & mask;
        return hi * lo;
    endfunction

endpackage

// File: rtl/rom_file_mult_if.sv
// Read port bundle of the ROM multiplier: address/strobe toward the ROM,
// registered word and valid back.
interface rom_file_mult_if #(parameter int N = 2);

    logic [N-1:0] address;
    logic         read_en;
    logic [N-1:0] data;
    logic         data_valid;

    modport master (output address, output read_en, input data, input data_valid);
    modport slave  (input address, input read_en, output data, output data_valid);

endinterface

// File: rtl/rom_file_array.sv
// Combinational multiplication table, 2^N words of N bits, filled at
// elaboration from mult_entry.
module rom_file_array
    import rom_file_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] address,
    output logic [N-1:0] word
);

    localparam int DEPTH = rom_depth(N);

    logic [N-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [MAX_N-1:0] ENTRY = mult_entry(i, N);
        assign rom[i] = ENTRY[N-1:0];
    end

    assign word = rom[address];

endmodule

// File: rtl/rom_file_mult.sv
// ROM-based multiplier with registered read. Defining ROM_FILE_OUTREG_EN adds a
// second output register stage (2-cycle latency instead of 1).
module rom_file_mult
    import rom_file_pkg::*;
#(
    parameter int N = 2
) (
    input  logic            clk,
    input  logic            rst,
    rom_file_mult_if.slave  bus
);

    if ((N % 2) != 0 || N < 2 || N > MAX_N) begin : g_bad_n
        $fatal(1, "rom_file_mult: N must be even and in 2..%0d, got %0d", MAX_N, N);
    end

    logic [N-1:0] word;
    logic [N-1:0] s1_data;
    logic         s1_valid;

    rom_file_array #(.N(N)) u_array (
        .address (bus.address),
        .word    (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= bus.read_en;
            if (bus.read_en) s1_data <= word;
        end
    end

`ifdef ROM_FILE_OUTREG_EN
    logic [N-1:0] s2_data;
    logic         s2_valid;

    // Stage 2 only follows stage 1 when it carries a fresh word, so idle
    // cycles keep the last product on the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_data  <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) s2_data <= s1_data;
        end
    end

    assign bus.data       = s2_data;
    assign bus.data_valid = s2_valid;
`else
    assign bus.data       = s1_data;
    assign bus.data_valid = s1_valid;
`endif

endmodule

// File: tb/tb_rom_file_mult.sv
// Randomized and directed check of rom_file_mult at N=2 and N=4 against a
// read-history model of the multiplication table.
module tb_rom_file_mult;

`ifdef ROM_FILE_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_chk  = 0;
    int n_pass = 0;

    rom_file_mult_if #(.N(2)) b2 ();
    rom_file_mult_if #(.N(4)) b4 ();

    rom_file_mult #(.N(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    rom_file_mult #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    always #5 clk = ~clk;

    // Model: per-DUT history of (strobe, address), newest first.
    bit          h2_en[$];
    int unsigned h2_a[$];
    bit          h4_en[$];
    int unsigned h4_a[$];
    int unsigned m2_d = 0;
    bit          m2_v = 0;
    int unsigned m4_d = 0;
    bit          m4_v = 0;

    function automatic int unsigned prod(input int unsigned a, input int n);
        int unsigned half;
        half = 1 << (n / 2);
        return (a / half) * (a % half);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        h2_en.delete(); h2_a.delete(); h4_en.delete(); h4_a.delete();
        m2_d = 0; m2_v = 0; m4_d = 0; m4_v = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_d2"}, 32'(b2.data), m2_d);
        chk({tag, "_v2"}, 32'(b2.data_valid), 32'(m2_v));
        chk({tag, "_d4"}, 32'(b4.data), m4_d);
        chk({tag, "_v4"}, 32'(b4.data_valid), 32'(m4_v));
    endtask

    task automatic step(input bit e2, input int unsigned x2, input bit e4, input int unsigned x4,
                        input string tag);
        b2.read_en = e2; b2.address = x2[1:0];
        b4.read_en = e4; b4.address = x4[3:0];
        @(posedge clk);
        #1;
        h2_en.push_front(e2); h2_a.push_front(x2 & 3);
        h4_en.push_front(e4); h4_a.push_front(x4 & 15);
        while (h2_en.size() > LAT) begin void'(h2_en.pop_back()); void'(h2_a.pop_back()); end
        while (h4_en.size() > LAT) begin void'(h4_en.pop_back()); void'(h4_a.pop_back()); end
        m2_v = (h2_en.size() == LAT) && h2_en[LAT-1];
        if (m2_v) m2_d = prod(h2_a[LAT-1], 2);
        m4_v = (h4_en.size() == LAT) && h4_en[LAT-1];
        if (m4_v) m4_d = prod(h4_a[LAT-1], 4);
        check_all(tag);
    endtask

    initial begin
        b2.read_en = 1'b0; b2.address = '0;
        b4.read_en = 1'b0; b4.address = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #3 rst = 1'b0;

        // N=2 exhaustive sweep alongside N=4 directed corners
        step(1, 0, 1, 4'b1111, "sweep0");
        step(1, 1, 1, 4'b1011, "sweep1");
        step(1, 2, 1, 4'b1111, "sweep2");
        step(1, 3, 0, 4'b0000, "sweep3");
        for (int i = 0; i < LAT; i++) step(0, 0, 0, 0, "drain");
        chk("n4_1111_hold", 32'(b4.data), 32'd9);
        chk("n2_11", 32'(b2.data), 32'd1);

        // Hold with toggling address
        for (int i = 0; i < 6; i++) step(0, $urandom, 0, $urandom, "hold");
        chk("hold_data", 32'(b4.data), 32'd9);

        // Back-to-back full N=4 sweep
        for (int a = 0; a < 16; a++) step(1, a & 3, 1, a, "b2b");
        for (int i = 0; i < LAT; i++) step(0, 0, 0, 0, "b2b_tail");

        // Random traffic
        for (int i = 0; i < 300; i++)
            step(bit'($urandom_range(1)), $urandom, bit'($urandom_range(1)), $urandom, "rand");

        // Asynchronous reset mid-stream with reads in flight
        b2.read_en = 1'b1; b2.address = 2'b11;
        b4.read_en = 1'b1; b4.address = 4'b1111;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");

        // Reset wins over a simultaneous read
        @(posedge clk);
        #1;
        check_all("rst_vs_read");

        // Release and read 0101 on the first edge
        #3 rst = 1'b0;
        step(0, 0, 1, 4'b0101, "rel0");
        for (int i = 1; i < LAT; i++) step(0, 0, 0, 0, "rel_wait");
        chk("rel_0101", 32'(b4.data), 32'd1);
        chk("rel_0101_v", 32'(b4.data_valid), 32'd1);
        step(0, 0, 0, 0, "rel_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
